rx_latency_meter: RTL and testbench

//  Downstream consumer of the free-running timestamp counter. Watches the RX

---
 rtl/rx_latency_meter.sv | 99 +++++++++
 tb/tb_rx_latency_meter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_latency_meter.sv
// rx_latency_meter: per-frame RX latency measurement with running min/max/sum/count statistics
module rx_latency_meter #(
  parameter int TS_DWIDTH      = 64,
  parameter int TS_WORD_OFFSET = 1,
  parameter int SUM_DWIDTH     = 80,
  parameter int CNT_DWIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [TS_DWIDTH-1:0]  counter_val,
  input  logic                  rx_valid,
  input  logic                  rx_sof,
  input  logic                  rx_eof,
  input  logic [TS_DWIDTH-1:0]  rx_data,
  input  logic                  stats_clear,
  output logic                  latency_valid,
  output logic [TS_DWIDTH-1:0]  latency,
  output logic [TS_DWIDTH-1:0]  lat_min,
  output logic [TS_DWIDTH-1:0]  lat_max,
  output logic [SUM_DWIDTH-1:0] lat_sum,
  output logic [CNT_DWIDTH-1:0] frame_cnt,
  output logic [CNT_DWIDTH-1:0] short_cnt
);
  localparam int IW = $clog2(TS_WORD_OFFSET + 1) + 1;
  typedef enum logic [1:0] {IDLE, WAIT_TS, WAIT_EOF} state_t;
  state_t               state;
  logic [TS_DWIDTH-1:0] arr_ts;
  logic [IW-1:0]        word_idx;
  logic                 sof, eof, ts_hit, fire;
  logic [TS_DWIDTH-1:0] lat_new;
  logic [1:0]           short_inc;
  logic [SUM_DWIDTH:0]  sum_ext;
  logic [CNT_DWIDTH:0]  short_ext;
  // frame decode: TS word detection, latency subtraction and short-frame events
  always_comb begin
    sof       = rx_valid & rx_sof;
    eof       = rx_valid & rx_eof;
    ts_hit    = rx_valid & !rx_sof & (state == WAIT_TS) & (word_idx == IW'(TS_WORD_OFFSET));
    fire      = (TS_WORD_OFFSET == 0) ? sof : ts_hit;
    lat_new   = ((TS_WORD_OFFSET == 0) ? counter_val : arr_ts) - rx_data;
    short_inc = {1'b0, (TS_WORD_OFFSET != 0) & sof & (state == WAIT_TS)}
              + {1'b0, (TS_WORD_OFFSET != 0) & eof & (sof | ((state == WAIT_TS) & !ts_hit))};
    sum_ext   = {1'b0, lat_sum} + {{(SUM_DWIDTH + 1 - TS_DWIDTH){1'b0}}, latency};
    short_ext = {1'b0, short_cnt} + {{(CNT_DWIDTH - 1){1'b0}}, short_inc};
  end
  // frame tracking FSM: a new SOF always restarts, abandoning any frame in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      arr_ts   <= '0;
      word_idx <= '0;
    end else if (sof) begin
      arr_ts   <= counter_val;
      word_idx <= IW'(1);
      state    <= eof ? IDLE : (TS_WORD_OFFSET == 0) ? WAIT_EOF : WAIT_TS;
    end else if (rx_valid) begin
      if (state == WAIT_TS) begin
        word_idx <= word_idx + IW'(1);
        state    <= eof ? IDLE : ts_hit ? WAIT_EOF : WAIT_TS;
      end else if (state == WAIT_EOF && eof) begin
        state <= IDLE;
      end
    end
  end
  // latency sample register, presented one cycle after the TS word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latency_valid <= 1'b0;
      latency       <= '0;
    end else begin
      latency_valid <= fire;
      if (fire) latency <= lat_new;
    end
  end
  // statistics: fold in each sample one cycle after presentation; clear wins over updates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_min   <= '1;
      lat_max   <= '0;
      lat_sum   <= '0;
      frame_cnt <= '0;
      short_cnt <= '0;
    end else if (stats_clear) begin
      lat_min   <= '1;
      lat_max   <= '0;
      lat_sum   <= '0;
      frame_cnt <= '0;
      short_cnt <= '0;
    end else begin
      if (latency_valid) begin
        lat_min   <= (latency < lat_min) ? latency : lat_min;
        lat_max   <= (latency > lat_max) ? latency : lat_max;
        lat_sum   <= sum_ext[SUM_DWIDTH] ? '1 : sum_ext[SUM_DWIDTH-1:0];
        frame_cnt <= (&frame_cnt) ? frame_cnt : frame_cnt + CNT_DWIDTH'(1);
      end
      short_cnt <= short_ext[CNT_DWIDTH] ? '1 : short_ext[CNT_DWIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_rx_latency_meter.sv
// tb_rx_latency_meter: randomized self-checking bench against a frame-level reference model
module tb_rx_latency_meter;
  localparam int W  = 64;
  localparam int SW = 80;
  localparam int CW = 32;
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  counter_val = '0;
  logic          rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0, stats_clear = 1'b0;
  logic [W-1:0]  rx_data = '0;
  logic          latency_valid;
  logic [W-1:0]  latency, lat_min, lat_max;
  logic [SW-1:0] lat_sum;
  logic [CW-1:0] frame_cnt, short_cnt;
  int checks = 0;
  int errors = 0;
  logic [W-1:0]  got_q[$];
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  m_min, m_max;
  logic [SW-1:0] m_sum;
  logic [CW-1:0] m_cnt, m_short;

  rx_latency_meter dut (
    .clk(clk), .reset_n(reset_n), .counter_val(counter_val), .rx_valid(rx_valid),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_data(rx_data), .stats_clear(stats_clear),
    .latency_valid(latency_valid), .latency(latency), .lat_min(lat_min), .lat_max(lat_max),
    .lat_sum(lat_sum), .frame_cnt(frame_cnt), .short_cnt(short_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reset_n && latency_valid) got_q.push_back(latency);

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic void model_clear();
    m_min = '1; m_max = '0; m_sum = '0; m_cnt = '0; m_short = '0;
  endfunction

  function automatic void model_sample(input logic [W-1:0] lat);
    logic [SW:0] t;
    exp_q.push_back(lat);
    if (lat < m_min) m_min = lat;
    if (lat > m_max) m_max = lat;
    t = {1'b0, m_sum} + SW'(lat);
    m_sum = t[SW] ? '1 : t[SW-1:0];
    if (m_cnt != '1) m_cnt++;
  endfunction

  task automatic drive(input bit v, input bit s, input bit e, input logic [W-1:0] d,
                       input logic [W-1:0] c, input bit clr = 1'b0);
    @(negedge clk);
    rx_valid = v; rx_sof = s; rx_eof = e; rx_data = d; counter_val = c; stats_clear = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, '0, rnd64());
  endtask

  // frame of len words; word 1 carries tx; valid=0 filler words carry random sof/eof noise
  task automatic send_frame(input logic [W-1:0] arr, input logic [W-1:0] tx, input int len,
                            input bit eof_end, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps)
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 0; g++)
          drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd64(), rnd64());
      drive(1, i == 0, eof_end && i == len - 1, (i == 1) ? tx : rnd64(), (i == 0) ? arr : rnd64());
    end
    if (len >= 2) model_sample(arr - tx);
    else m_short++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (latency_valid !== 1'b0) begin errors++; $display("FAIL reset_lv got %0b exp 0", latency_valid); end
    checks++; if (latency !== '0) begin errors++; $display("FAIL reset_latency got %h exp 0", latency); end
    checks++; if (lat_min !== '1) begin errors++; $display("FAIL reset_min got %h exp all-ones", lat_min); end
    checks++; if (lat_max !== '0) begin errors++; $display("FAIL reset_max got %h exp 0", lat_max); end
    checks++; if (lat_sum !== '0) begin errors++; $display("FAIL reset_sum got %h exp 0", lat_sum); end
    checks++; if (frame_cnt !== '0 || short_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", frame_cnt, short_cnt); end
    got_q.delete();
    drive(1, 1, 0, rnd64(), 64'h500);
    drive(0, 0, 0, '0, '0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 0, 0, 64'h100, '0);
    drive(1, 0, 1, rnd64(), '0);
    idle(3);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL reset_midframe got %0d samples exp 0", got_q.size()); end
    checks++; if (short_cnt !== '0) begin errors++; $display("FAIL reset_midframe_short got %0d exp 0", short_cnt); end
  endtask

  task automatic test_single();
    got_q.delete(); exp_q.delete();
    drive(1, 1, 0, rnd64(), 64'h1000);
    drive(1, 0, 0, 64'h0F00, rnd64());
    drive(1, 0, 0, rnd64(), rnd64());
    checks++; if (latency_valid !== 1'b1 || latency !== 64'h100) begin errors++; $display("FAIL single_k1 got lv=%0b lat=%h exp lv=1 lat=100", latency_valid, latency); end
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL single_early_cnt got %0d exp 0", frame_cnt); end
    drive(1, 0, 1, rnd64(), rnd64());
    checks++; if (latency_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %0b exp 0", latency_valid); end
    checks++; if (lat_min !== 64'h100 || lat_max !== 64'h100) begin errors++; $display("FAIL single_minmax got %h/%h exp 100/100", lat_min, lat_max); end
    checks++; if (lat_sum !== SW'(64'h100) || frame_cnt !== 1) begin errors++; $display("FAIL single_sum got %h/%0d exp 100/1", lat_sum, frame_cnt); end
    idle(3);
    model_sample(64'h100);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL single_samples got %0d exp 1", got_q.size()); end
  endtask

  task automatic test_wrap();
    got_q.delete(); exp_q.delete();
    send_frame(64'h5, 64'hFFFF_FFFF_FFFF_FFFB, 2, 1, 0);
    idle(3);
    checks++; if (latency !== 64'hA) begin errors++; $display("FAIL wrap got %h exp a", latency); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL wrap_samples got %0d exp %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_stats();
    drive(0, 0, 0, '0, '0, 1);
    model_clear();
    got_q.delete(); exp_q.delete();
    send_frame(64'h2040, 64'h2000, 3, 1, 0);
    send_frame(64'h3010, 64'h3000, 2, 1, 0);
    send_frame(64'h4080, 64'h4000, 4, 1, 0);
    idle(3);
    checks++; if (lat_min !== 64'h10 || lat_max !== 64'h80) begin errors++; $display("FAIL stats_minmax got %h/%h exp 10/80", lat_min, lat_max); end
    checks++; if (lat_sum !== SW'(64'hD0) || frame_cnt !== 3) begin errors++; $display("FAIL stats_sum got %h/%0d exp d0/3", lat_sum, frame_cnt); end
    checks++; if (got_q != exp_q) begin errors++; $display("FAIL stats_samples got %0d samples exp %0d", got_q.size(), exp_q.size()); end
    drive(0, 0, 0, '0, '0, 1);
    idle(2);
    model_clear();
    checks++; if (lat_min !== '1 || lat_max !== '0 || lat_sum !== '0 || frame_cnt !== '0) begin errors++; $display("FAIL stats_clear got %h/%h/%h/%0d exp reset values", lat_min, lat_max, lat_sum, frame_cnt); end
    checks++; if (latency !== 64'h80) begin errors++; $display("FAIL stats_clear_latency got %h exp 80", latency); end
  endtask

  task automatic test_short();
    got_q.delete(); exp_q.delete();
    send_frame(rnd64(), rnd64(), 1, 1, 0);
    send_frame(rnd64(), rnd64(), 1, 0, 0);
    send_frame(64'h3000, 64'h2F80, 3, 1, 0);
    idle(3);
    checks++; if (short_cnt !== 2) begin errors++; $display("FAIL short_cnt got %0d exp 2", short_cnt); end
    checks++; if (frame_cnt !== 1) begin errors++; $display("FAIL short_frame_cnt got %0d exp 1", frame_cnt); end
    checks++; if (latency !== 64'h80 || got_q.size() !== 1) begin errors++; $display("FAIL short_restart got %h (%0d samples) exp 80 (1)", latency, got_q.size()); end
  endtask

  task automatic test_gaps_contention();
    got_q.delete(); exp_q.delete();
    drive(1, 1, 0, rnd64(), 64'h9000);
    drive(0, 1, 1, 64'h1111, rnd64());
    drive(0, 0, 0, 64'h2222, rnd64());
    drive(1, 0, 0, 64'h8F00, rnd64());
    drive(0, 0, 1, 64'h3333, rnd64());
    drive(1, 0, 1, rnd64(), rnd64());
    idle(3);
    model_sample(64'h100);
    checks++; if (latency !== 64'h100 || got_q.size() !== 1) begin errors++; $display("FAIL gaps got %h (%0d samples) exp 100 (1)", latency, got_q.size()); end
    checks++; if (frame_cnt !== 2) begin errors++; $display("FAIL gaps_cnt got %0d exp 2", frame_cnt); end
    drive(1, 1, 0, rnd64(), 64'h700);
    drive(1, 0, 0, 64'h6C0, rnd64());
    drive(1, 0, 1, rnd64(), rnd64(), 1);
    checks++; if (latency_valid !== 1'b1 || latency !== 64'h40) begin errors++; $display("FAIL contention_lv got lv=%0b lat=%h exp lv=1 lat=40", latency_valid, latency); end
    idle(3);
    model_clear();
    checks++; if (frame_cnt !== '0 || lat_sum !== '0 || lat_min !== '1) begin errors++; $display("FAIL contention_stats got %0d/%h/%h exp 0/0/all-ones", frame_cnt, lat_sum, lat_min); end
  endtask

  task automatic test_random();
    int n;
    bit e;
    drive(0, 0, 0, '0, '0, 1);
    idle(1);
    model_clear();
    got_q.delete(); exp_q.delete();
    n = 60;
    for (int f = 0; f < n; f++) begin
      e = (f == n - 1) || ($urandom_range(0, 4) != 0);
      send_frame(($urandom_range(0, 1) == 0) ? rnd64() : 64'(32'($urandom)),
                 ($urandom_range(0, 1) == 0) ? rnd64() : 64'(16'($urandom)),
                 int'($urandom_range(1, 5)), e, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(3);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_samples got %0d exp %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_latency[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (lat_min !== m_min || lat_max !== m_max) begin errors++; $display("FAIL rand_minmax got %h/%h exp %h/%h", lat_min, lat_max, m_min, m_max); end
    checks++; if (lat_sum !== m_sum) begin errors++; $display("FAIL rand_sum got %h exp %h", lat_sum, m_sum); end
    checks++; if (frame_cnt !== m_cnt || short_cnt !== m_short) begin errors++; $display("FAIL rand_counts got %0d/%0d exp %0d/%0d", frame_cnt, short_cnt, m_cnt, m_short); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_wrap();
    test_stats();
    test_short();
    test_gaps_contention();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
